rng_input_ctrl: RTL and testbench

//  Front-end controller feeding the 4-bit LFSR random-number stage. Turns raw pushbuttons and seed switches

---
 rtl/rng_pkg.sv | 17 +
 rtl/rng_debounce.sv | 51 +++++
 rtl/rng_input_ctrl.sv | 124 ++++++++++++
 tb/tb_rng_input_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared types and constants for the RNG front-end controller and the LFSR stage.
package rng_pkg;

  typedef enum logic [1:0] {INIT, LOAD, RUN, LOCKOUT} rng_state_t;

  localparam int SEED_W = 4;
  localparam int CNT_W  = 8;

  localparam logic [SEED_W-1:0] DEFAULT_SEED = 4'b1001;

  // An all-zero seed would lock the LFSR, so substitute a known-good one.
  function automatic logic [SEED_W-1:0] guard_seed(input logic [SEED_W-1:0] s,
                                                   input logic [SEED_W-1:0] dflt);
    return (s == '0) ? dflt : s;
  endfunction

endpackage

// File: rtl/rng_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stability down-counter and
// single-cycle rising-edge pulse on the accepted (debounced) level.
module rng_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic            r_pulse;
  logic [DB_W-1:0] r_cnt;
  logic            w_settled;

  assign w_settled = (r_cnt == '0);

  // A 1-bit input can only toggle back to the accepted level, so reloading
  // whenever synced == level restarts the count on every change.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
      r_cnt   <= DB_LOAD;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_pulse <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= DB_LOAD;
      end else if (w_settled) begin
        r_level <= r_sync2;
        r_pulse <= r_sync2;
        r_cnt   <= DB_LOAD;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/rng_input_ctrl.sv
// Front-end controller for the 4-bit LFSR: debounced seed/catch strobes,
// catch lockout and catch counter. Optional RNG_AUTO_SEED_EN mixes an entropy counter into the seed.
module rng_input_ctrl
  import rng_pkg::*;
#(
  parameter int                DEBOUNCE_CYCLES = 50000,
  parameter int                LOCKOUT_CYCLES  = 16,
  parameter logic [SEED_W-1:0] DEFAULT_SEED    = rng_pkg::DEFAULT_SEED
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_btn_catch,
  input  logic              i_btn_seed,
  input  logic [SEED_W-1:0] i_sw_seed,
  output logic [SEED_W-1:0] o_seed,
  output logic              o_load_shift,
  output logic              o_number_catch,
  output logic [CNT_W-1:0]  o_catch_count,
  output logic              o_locked
);

  localparam int LK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LK_W-1:0] LK_LOAD = LK_W'(LOCKOUT_CYCLES - 1);

  rng_state_t        r_state;
  rng_state_t        w_next_state;
  logic [LK_W-1:0]   r_lk_cnt;
  logic [SEED_W-1:0] r_seed;
  logic              r_load_shift;
  logic              r_number_catch;
  logic [CNT_W-1:0]  r_catch_count;
  logic              r_locked;
  logic              w_catch_pulse;
  logic              w_seed_pulse;
  logic [SEED_W-1:0] w_sel_seed;
  logic              w_load_next;
  logic              w_catch_next;
  logic              w_lock_next;

  rng_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_catch (
    .i_clk   (i_clk),
    .i_rst_n (i_reset),
    .i_btn   (i_btn_catch),
    .o_pulse (w_catch_pulse)
  );

  rng_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_seed (
    .i_clk   (i_clk),
    .i_rst_n (i_reset),
    .i_btn   (i_btn_seed),
    .o_pulse (w_seed_pulse)
  );

`ifdef RNG_AUTO_SEED_EN
  logic [SEED_W-1:0] r_entropy;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_entropy <= '0;
    else          r_entropy <= r_entropy + 1'b1;
  end

  assign w_sel_seed = guard_seed(r_entropy ^ i_sw_seed, DEFAULT_SEED);
`else
  assign w_sel_seed = guard_seed(i_sw_seed, DEFAULT_SEED);
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= INIT;
    else          r_state <= w_next_state;
  end

  // Seed pulse takes priority over catch in every state that listens.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      INIT:    w_next_state = LOAD;
      LOAD:    w_next_state = RUN;
      RUN: begin
        if (w_seed_pulse)       w_next_state = LOAD;
        else if (w_catch_pulse) w_next_state = LOCKOUT;
      end
      LOCKOUT: begin
        if (w_seed_pulse)         w_next_state = LOAD;
        else if (r_lk_cnt == '0)  w_next_state = RUN;
      end
      default: w_next_state = INIT;
    endcase
  end

  // Outputs are registered from the next state so a pulse at t strobes at t+1.
  always_comb begin
    w_load_next  = (w_next_state == LOAD);
    w_catch_next = (r_state == RUN) && (w_next_state == LOCKOUT);
    w_lock_next  = (w_next_state == LOCKOUT);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_seed         <= DEFAULT_SEED;
      r_load_shift   <= 1'b0;
      r_number_catch <= 1'b0;
      r_catch_count  <= '0;
      r_locked       <= 1'b0;
      r_lk_cnt       <= LK_LOAD;
    end else begin
      r_load_shift   <= w_load_next;
      r_number_catch <= w_catch_next;
      r_locked       <= w_lock_next;
      if (w_load_next)  r_seed        <= w_sel_seed;
      if (w_catch_next) r_catch_count <= r_catch_count + 1'b1;
      if (w_catch_next)
        r_lk_cnt <= LK_LOAD;
      else if ((r_state == LOCKOUT) && (r_lk_cnt != '0))
        r_lk_cnt <= r_lk_cnt - 1'b1;
    end
  end

  assign o_seed         = r_seed;
  assign o_load_shift   = r_load_shift;
  assign o_number_catch = r_number_catch;
  assign o_catch_count  = r_catch_count;
  assign o_locked       = r_locked;

endmodule

// File: tb/tb_rng_input_ctrl.sv
// Directed bench for rng_input_ctrl (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=3), plus a
// second instance with a 16-cycle lockout so a catch press can land inside the window.
module tb_rng_input_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_catch, btn_seed, btn_catch2, btn_seed2;
  logic [3:0] sw_seed;
  logic [3:0] seed, seed2;
  logic       load_shift, number_catch, locked;
  logic       load_shift2, number_catch2, locked2;
  logic [7:0] catch_count, catch_count2;

  int errors = 0;
  int checks = 0;
  int n_load = 0, n_catch = 0, n_lock = 0, n_both = 0;
  logic [3:0] last_seed = 4'h0;
  logic [7:0] exp_cc = 8'h00;

  always #5 clk = ~clk;

  rng_input_ctrl #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(3)) u_dut (
    .i_clk(clk), .i_reset(rst_n), .i_btn_catch(btn_catch), .i_btn_seed(btn_seed),
    .i_sw_seed(sw_seed), .o_seed(seed), .o_load_shift(load_shift),
    .o_number_catch(number_catch), .o_catch_count(catch_count), .o_locked(locked)
  );

  rng_input_ctrl #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(16)) u_dut_lk (
    .i_clk(clk), .i_reset(rst_n), .i_btn_catch(btn_catch2), .i_btn_seed(btn_seed2),
    .i_sw_seed(sw_seed), .o_seed(seed2), .o_load_shift(load_shift2),
    .o_number_catch(number_catch2), .o_catch_count(catch_count2), .o_locked(locked2)
  );

  always @(negedge clk) begin
    if (load_shift) begin
      n_load++;
      last_seed = seed;
    end
    if (number_catch) n_catch++;
    if (locked) n_lock++;
    if (load_shift && number_catch) n_both++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; btn_catch = 1'b0; btn_seed = 1'b0; btn_catch2 = 1'b0; btn_seed2 = 1'b0;
    sw_seed = 4'b1010;
    repeat (3) tick();
    checks++; if (seed !== 4'b1001) begin errors++; $display("FAIL rst_seed: got %b expected 1001", seed); end
    checks++; if (load_shift !== 1'b0) begin errors++; $display("FAIL rst_load_shift: got %b expected 0", load_shift); end
    checks++; if (number_catch !== 1'b0) begin errors++; $display("FAIL rst_number_catch: got %b expected 0", number_catch); end
    checks++; if (catch_count !== 8'h00) begin errors++; $display("FAIL rst_catch_count: got %0d expected 0", catch_count); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked: got %b expected 0", locked); end
  endtask

  task automatic test_init_load;
    int b_load;
    b_load = n_load;
    rst_n = 1'b1;
    tick();
    checks++; if (load_shift !== 1'b1) begin errors++; $display("FAIL init_load_shift: got %b expected 1", load_shift); end
    checks++; if (seed !== 4'b1010) begin errors++; $display("FAIL init_seed: got %b expected 1010", seed); end
    checks++; if (number_catch !== 1'b0) begin errors++; $display("FAIL init_number_catch: got %b expected 0", number_catch); end
    tick();
    checks++; if (load_shift !== 1'b0) begin errors++; $display("FAIL init_load_shift_end: got %b expected 0", load_shift); end
    checks++; if (seed !== 4'b1010) begin errors++; $display("FAIL init_seed_held: got %b expected 1010", seed); end
    checks++; if (n_load - b_load !== 1) begin errors++; $display("FAIL init_load_count: got %0d expected 1", n_load - b_load); end
  endtask

  task automatic test_seed_zero_guard;
    int b_load;
    b_load = n_load;
    sw_seed = 4'b0000;
    btn_seed = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 6) begin
        checks++; if (load_shift !== 1'b0) begin errors++; $display("FAIL seed_early: got %b expected 0", load_shift); end
      end
      if (i == 7) begin
        checks++; if (load_shift !== 1'b1) begin errors++; $display("FAIL seed_latency: got %b expected 1", load_shift); end
        checks++; if (seed !== 4'b1001) begin errors++; $display("FAIL seed_zero_guard: got %b expected 1001", seed); end
      end
    end
    btn_seed = 1'b0;
    repeat (10) tick();
    checks++; if (n_load - b_load !== 1) begin errors++; $display("FAIL seed_held_once: got %0d expected 1", n_load - b_load); end
    checks++; if (last_seed !== 4'b1001) begin errors++; $display("FAIL seed_last: got %b expected 1001", last_seed); end
  endtask

  task automatic test_catch;
    int b_catch, b_lock;
    b_catch = n_catch;
    btn_catch = 1'b1;
    repeat (3) tick();
    btn_catch = 1'b0;
    repeat (8) tick();
    checks++; if (n_catch - b_catch !== 0) begin errors++; $display("FAIL glitch_catch: got %0d expected 0", n_catch - b_catch); end
    checks++; if (catch_count !== 8'h00) begin errors++; $display("FAIL glitch_count: got %0d expected 0", catch_count); end
    b_lock = n_lock;
    btn_catch = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 6) begin
        checks++; if (number_catch !== 1'b0) begin errors++; $display("FAIL catch_early: got %b expected 0", number_catch); end
        btn_catch = 1'b0;
      end
      if (i == 7) begin
        exp_cc = 8'h01;
        checks++; if (number_catch !== 1'b1) begin errors++; $display("FAIL catch_strobe: got %b expected 1", number_catch); end
        checks++; if (catch_count !== exp_cc) begin errors++; $display("FAIL catch_count: got %0d expected %0d", catch_count, exp_cc); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL catch_locked: got %b expected 1", locked); end
      end
      if (i == 8) begin
        checks++; if (number_catch !== 1'b0) begin errors++; $display("FAIL catch_one_cycle: got %b expected 0", number_catch); end
      end
      if (i == 10) begin
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lockout_end: got %b expected 0", locked); end
      end
    end
    repeat (2) tick();
    checks++; if (n_lock - b_lock !== 3) begin errors++; $display("FAIL lockout_len: got %0d expected 3", n_lock - b_lock); end
    checks++; if (n_catch - b_catch !== 1) begin errors++; $display("FAIL catch_total: got %0d expected 1", n_catch - b_catch); end
  endtask

  task automatic test_lockout_drop;
    int extra;
    extra = 0;
    btn_catch2 = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i > 7 && number_catch2) extra++;
      if (i == 6) btn_catch2 = 1'b0;
      if (i == 7) begin
        checks++; if (number_catch2 !== 1'b1) begin errors++; $display("FAIL lk_first_catch: got %b expected 1", number_catch2); end
        checks++; if (locked2 !== 1'b1) begin errors++; $display("FAIL lk_locked: got %b expected 1", locked2); end
      end
      if (i == 12) btn_catch2 = 1'b1;
      if (i == 14) btn_seed2 = 1'b1;
      if (i == 19) begin
        checks++; if (catch_count2 !== 8'h01) begin errors++; $display("FAIL lk_drop_count: got %0d expected 1", catch_count2); end
        checks++; if (locked2 !== 1'b1) begin errors++; $display("FAIL lk_still_locked: got %b expected 1", locked2); end
      end
      if (i == 20) begin
        btn_catch2 = 1'b0;
        btn_seed2 = 1'b0;
      end
      if (i == 21) begin
        checks++; if (load_shift2 !== 1'b1) begin errors++; $display("FAIL lk_seed_load: got %b expected 1", load_shift2); end
        checks++; if (locked2 !== 1'b0) begin errors++; $display("FAIL lk_seed_unlock: got %b expected 0", locked2); end
        checks++; if (seed2 !== 4'b1001) begin errors++; $display("FAIL lk_seed_value: got %b expected 1001", seed2); end
      end
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL lk_extra_catch: got %0d expected 0", extra); end
    checks++; if (catch_count2 !== 8'h01) begin errors++; $display("FAIL lk_final_count: got %0d expected 1", catch_count2); end
  endtask

  task automatic test_back_to_back;
    int b_load, b_catch, b_both;
    b_load = n_load; b_catch = n_catch; b_both = n_both;
    sw_seed = 4'b0101;
    btn_seed = 1'b1;
    btn_catch = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 6) begin
        btn_seed = 1'b0;
        btn_catch = 1'b0;
      end
      if (i == 7) begin
        checks++; if (load_shift !== 1'b1) begin errors++; $display("FAIL both_load: got %b expected 1", load_shift); end
        checks++; if (seed !== 4'b0101) begin errors++; $display("FAIL both_seed: got %b expected 0101", seed); end
      end
    end
    checks++; if (n_load - b_load !== 1) begin errors++; $display("FAIL both_load_count: got %0d expected 1", n_load - b_load); end
    checks++; if (n_catch - b_catch !== 0) begin errors++; $display("FAIL both_catch_dropped: got %0d expected 0", n_catch - b_catch); end
    checks++; if (catch_count !== exp_cc) begin errors++; $display("FAIL both_count: got %0d expected %0d", catch_count, exp_cc); end
    checks++; if (n_both - b_both !== 0) begin errors++; $display("FAIL both_overlap: got %0d expected 0", n_both - b_both); end
  endtask

  task automatic test_wrap;
    int b_catch;
    b_catch = n_catch;
    for (int k = 0; k < 255; k++) begin
      btn_catch = 1'b1;
      repeat (6) tick();
      btn_catch = 1'b0;
      repeat (7) tick();
      exp_cc = exp_cc + 8'h01;
      if (k == 253) begin
        checks++; if (catch_count !== 8'hFF) begin errors++; $display("FAIL wrap_255: got %0d expected 255", catch_count); end
      end
    end
    checks++; if (catch_count !== 8'h00) begin errors++; $display("FAIL wrap_zero: got %0d expected 0", catch_count); end
    checks++; if (n_catch - b_catch !== 255) begin errors++; $display("FAIL wrap_strobes: got %0d expected 255", n_catch - b_catch); end
  endtask

  task automatic test_reset_mid_lockout;
    int b_load, b_catch;
    btn_catch = 1'b1;
    repeat (7) tick();
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL pre_rst_locked: got %b expected 1", locked); end
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (seed !== 4'b1001) begin errors++; $display("FAIL async_seed: got %b expected 1001", seed); end
    checks++; if (load_shift !== 1'b0) begin errors++; $display("FAIL async_load_shift: got %b expected 0", load_shift); end
    checks++; if (number_catch !== 1'b0) begin errors++; $display("FAIL async_number_catch: got %b expected 0", number_catch); end
    checks++; if (catch_count !== 8'h00) begin errors++; $display("FAIL async_count: got %0d expected 0", catch_count); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL async_locked: got %b expected 0", locked); end
    btn_catch = 1'b0;
    repeat (3) tick();
    b_load = n_load; b_catch = n_catch;
    sw_seed = 4'b0011;
    rst_n = 1'b1;
    repeat (20) tick();
    checks++; if (n_load - b_load !== 1) begin errors++; $display("FAIL post_rst_loads: got %0d expected 1", n_load - b_load); end
    checks++; if (n_catch - b_catch !== 0) begin errors++; $display("FAIL post_rst_catches: got %0d expected 0", n_catch - b_catch); end
    checks++; if (last_seed !== 4'b0011) begin errors++; $display("FAIL post_rst_seed: got %b expected 0011", last_seed); end
    checks++; if (catch_count !== 8'h00) begin errors++; $display("FAIL post_rst_count: got %0d expected 0", catch_count); end
  endtask

  initial begin
    test_reset();
    test_init_load();
    test_seed_zero_guard();
    test_catch();
    test_lockout_drop();
    test_back_to_back();
    test_wrap();
    test_reset_mid_lockout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
